stride_gather: RTL
==================

Name: stride_gather

Overview:
- Sequential, run-time-configurable successor to the fixed combinational stride selector in the PAL datapath.
- Accepts an LEN-bit vector over a valid/ready handshake and splits it into stride-sized groups.
- Produces one result bit per group: pick a bit at an offset, AND-reduce the group, or OR-reduce the group.
- Processes one group per clock and presents the packed result on a valid/ready output port.

Parameters:
- LEN, 16, input vector width; also the maximum result width.
- MAX_STRIDE, 4, largest legal run-time stride. Must satisfy 1 <= MAX_STRIDE <= LEN.
- SW (derived), $clog2(MAX_STRIDE+1), width of the stride and offset fields.
- CW (derived), $clog2(LEN+1), width of the result count.

Ports:
- clk  in  1  clock; single clock domain.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  input vector offered.
- in_ready  out  1  block can accept a vector.
- in_data  in  LEN  vector to gather.
- cfg_stride  in  SW  group size, legal range 1..MAX_STRIDE.
- cfg_offset  in  SW  bit index within a group (PICK mode); legal range 0..stride-1.
- cfg_mode  in  2  0=PICK, 1=AND, 2=OR, 3=reserved.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- out_data  out  LEN  packed result; bit g = result of group g.
- out_count  out  CW  number of valid result bits N.
- busy  out  1  high in RUN or DONE.
- cfg_err  out  1  one-cycle pulse when a start is rejected.

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE; in_ready=1; out_valid=0; out_data=0; out_count=0; busy=0; cfg_err=0. Reset mid-operation discards the transfer in progress; out_valid is never raised for it.
- Group definition: group g covers bits [g*S, g*S+S-1], clipped to LEN-1. The number of groups is N = ceil(LEN/S).
- FSM IDLE:
  - in_ready=1.
  - On in_valid, check the config: S==0, S>MAX_STRIDE, mode==3, or (mode==PICK and offset>=S) → reject. A rejected start pulses cfg_err for one cycle and stays in IDLE, with no other state change.
  - On in_valid with a legal config: latch in_data, S, offset and mode; clear the accumulator; set g=0; go to RUN.
- FSM RUN:
  - in_ready=0.
  - Each cycle computes result bit g into out_data[g] and increments g.
  - After the cycle that computes g=N-1, go to DONE.
  - Config inputs and in_valid are ignored during RUN.
- FSM DONE:
  - out_valid=1; out_count=N; out_data is stable, and bits [LEN-1:N] are 0.
  - When out_ready=1, the next state is IDLE and out_valid drops on that edge.
  - in_ready=0 in DONE; there is no overlap with a new acceptance.
- Latency: acceptance at edge 0 → out_valid high after edge N+1 (N RUN cycles plus the DONE entry). For S=1, N=16, and out_valid rises 17 cycles after acceptance.
- Group reductions:
  - PICK: result = bit g*S+offset, or 0 if that index is >= LEN.
  - AND: out-of-range bits of a partial last group are masked to 1.
  - OR: out-of-range bits of a partial last group are masked to 0.
- out_data and out_count hold their last values in IDLE until the next acceptance clears them.
- Index arithmetic uses CW+SW-bit unsigned math so that g*S+offset never truncates.

Decomposition:
- Package stride_pkg holds:
  - the mode encodings MODE_PICK=2'd0, MODE_AND=2'd1, MODE_OR=2'd2;
  - the state encoding IDLE/RUN/DONE;
  - the function ceil_div(LEN,S) used to compute N.
- Sub-module stride_group_reduce (combinational) takes:
  - a MAX_STRIDE-bit window starting at g*S;
  - a per-bit in-range mask;
  - mode;
  - offset.
  It returns the one result bit.
- The top level holds the FSM, the latched vector, the group counter and the accumulator.

Test Plan:
- PICK, S=2, offset=0, in=16'hAAAA → out_data=16'h0000, out_count=8, out_valid 9 cycles after acceptance. Repeat with offset=1 → out_data=16'h00FF.
- AND, S=3, in=16'hFFFF → N=6, out_data=16'h003F. Then in=16'h7FFF → out_data=16'h001F (the partial group {bit15} gives 0).
- OR, S=4, in=16'h0100 → out_data=16'h0004, out_count=4. PICK, S=1, in=16'hBEEF → out_data=16'hBEEF, out_count=16, latency 17.
- Illegal configs: S=0; S=5; PICK with S=2, offset=2; mode=3 → each gives a single-cycle cfg_err pulse, with in_ready held at 1, busy=0 and no out_valid.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while driving in_valid=1 with a new vector → out_data stable and in_ready=0 throughout. Raise out_ready → IDLE on the next edge, and the new vector is accepted the cycle after.
- Reset at RUN cycle 3 (S=1): rst_n=0 for one edge → all outputs at their reset values on the next cycle and out_valid never asserts. A fresh transfer afterwards completes correctly.

Source files
------------

// File: rtl/stride_gather_pkg.sv
// Shared encodings and helpers for the stride gather block.
package stride_pkg;

   localparam logic [1:0] MODE_PICK = 2'd0;
   localparam logic [1:0] MODE_AND  = 2'd1;
   localparam logic [1:0] MODE_OR   = 2'd2;
   localparam logic [1:0] MODE_RSVD = 2'd3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   // Number of groups covering a vector of width a with group size b.
   function automatic int unsigned ceil_div(input int unsigned a, input int unsigned b);
      if (b == 0) return 0;
      return (a + b - 1) / b;
   endfunction

endpackage

// File: rtl/stride_gather_if.sv
// Input handshake, configuration and result port bundle for stride_gather.
interface stride_gather_if #(
   parameter int LEN        = 16,
   parameter int MAX_STRIDE = 4
);
   localparam int SW = $clog2(MAX_STRIDE + 1);
   localparam int CW = $clog2(LEN + 1);

   logic           in_valid;
   logic           in_ready;
   logic [LEN-1:0] in_data;
   logic [SW-1:0]  cfg_stride;
   logic [SW-1:0]  cfg_offset;
   logic [1:0]     cfg_mode;
   logic           out_valid;
   logic           out_ready;
   logic [LEN-1:0] out_data;
   logic [CW-1:0]  out_count;
   logic           busy;
   logic           cfg_err;

   modport master (
      output in_valid, in_data, cfg_stride, cfg_offset, cfg_mode, out_ready,
      input  in_ready, out_valid, out_data, out_count, busy, cfg_err
   );

   modport slave (
      input  in_valid, in_data, cfg_stride, cfg_offset, cfg_mode, out_ready,
      output in_ready, out_valid, out_data, out_count, busy, cfg_err
   );

endinterface

// File: rtl/stride_group_reduce.sv
// Reduces one stride-sized window to a single result bit.
module stride_group_reduce
   import stride_pkg::*;
#(
   parameter int MAX_STRIDE = 4,
   parameter int SW         = $clog2(MAX_STRIDE + 1)
) (
   input  logic [MAX_STRIDE-1:0] win_i,
   input  logic [MAX_STRIDE-1:0] mask_i,
   input  logic [1:0]            mode_i,
   input  logic [SW-1:0]         offset_i,
   output logic                  res_o
);

   logic pick;

   // Out-of-range bits read as 0 for PICK/OR and as 1 for AND.
   always_comb begin
      pick = 1'b0;
      for (int i = 0; i < MAX_STRIDE; i++) begin
         if (SW'(i) == offset_i) pick = win_i[i] & mask_i[i];
      end
      case (mode_i)
         MODE_PICK: res_o = pick;
         MODE_AND:  res_o = &(win_i | ~mask_i);
         MODE_OR:   res_o = |(win_i & mask_i);
         default:   res_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/stride_gather.sv
// Sequential stride gather: one group per clock, packed result on a valid/ready port.
module stride_gather
   import stride_pkg::*;
#(
   parameter int LEN        = 16,
   parameter int MAX_STRIDE = 4
) (
   input logic               clk,
   input logic               rst_n,
   stride_gather_if.slave    bus
);

   localparam int SW = $clog2(MAX_STRIDE + 1);
   localparam int CW = $clog2(LEN + 1);
   localparam int IW = CW + SW;

   state_e                state_q, state_d;
   logic [LEN-1:0]        data_q;
   logic [SW-1:0]         stride_q, offset_q;
   logic [1:0]            mode_q;
   logic [CW-1:0]         g_q, n_q, cnt_q;
   logic [LEN-1:0]        acc_q, acc_d;
   logic                  res_q, res_vld_q, res_last_q;
   logic [CW-1:0]         res_idx_q;
   logic                  cfg_err_q;

   logic                  cfg_ok, accept, reject, issue, res_bit;
   logic [CW-1:0]         n_d;
   logic [IW-1:0]         base;
   logic [MAX_STRIDE-1:0] win, mask;

   // Start-time config legality and group count.
   always_comb begin
      cfg_ok = (bus.cfg_stride != '0) &&
               (bus.cfg_stride <= SW'(MAX_STRIDE)) &&
               (bus.cfg_mode != MODE_RSVD) &&
               !((bus.cfg_mode == MODE_PICK) && (bus.cfg_offset >= bus.cfg_stride));
      n_d    = CW'(ceil_div(LEN, 32'(bus.cfg_stride)));
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic; DONE is entered once the last result bit is committed.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.in_valid && cfg_ok) state_d = RUN;
         RUN:     if (res_vld_q && res_last_q) state_d = DONE;
         DONE:    if (bus.out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Handshake outputs and datapath strobes.
   always_comb begin
      bus.in_ready  = (state_q == IDLE);
      bus.out_valid = (state_q == DONE);
      bus.busy      = (state_q == RUN) || (state_q == DONE);
      bus.cfg_err   = cfg_err_q;
      bus.out_data  = acc_q;
      bus.out_count = cnt_q;
      accept        = (state_q == IDLE) && bus.in_valid && cfg_ok;
      reject        = (state_q == IDLE) && bus.in_valid && !cfg_ok;
      issue         = (state_q == RUN) && !res_last_q;
   end

   // Window of the current group and its in-range mask (wide math avoids truncation).
   always_comb begin
      base = IW'(g_q) * IW'(stride_q);
      win  = MAX_STRIDE'(data_q >> base);
      for (int i = 0; i < MAX_STRIDE; i++) begin
         mask[i] = (SW'(i) < stride_q) && ((base + IW'(i)) < IW'(LEN));
      end
   end

   stride_group_reduce #(.MAX_STRIDE(MAX_STRIDE), .SW(SW)) u_reduce (
      .win_i    (win),
      .mask_i   (mask),
      .mode_i   (mode_q),
      .offset_i (offset_q),
      .res_o    (res_bit)
   );

   // Write the registered result bit into its slot of the accumulator.
   always_comb begin
      acc_d = acc_q;
      for (int i = 0; i < LEN; i++) begin
         if (CW'(i) == res_idx_q) acc_d[i] = res_q;
      end
   end

   // Datapath: latch on acceptance, compute one group per cycle, commit one cycle later.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         data_q     <= '0;
         stride_q   <= '0;
         offset_q   <= '0;
         mode_q     <= MODE_PICK;
         g_q        <= '0;
         n_q        <= '0;
         cnt_q      <= '0;
         acc_q      <= '0;
         res_q      <= 1'b0;
         res_vld_q  <= 1'b0;
         res_last_q <= 1'b0;
         res_idx_q  <= '0;
         cfg_err_q  <= 1'b0;
      end else begin
         cfg_err_q  <= reject;
         res_vld_q  <= issue;
         res_q      <= res_bit;
         res_idx_q  <= g_q;
         res_last_q <= issue && (g_q == n_q - CW'(1));
         if (accept) begin
            data_q   <= bus.in_data;
            stride_q <= bus.cfg_stride;
            offset_q <= bus.cfg_offset;
            mode_q   <= bus.cfg_mode;
            n_q      <= n_d;
            g_q      <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
         end else begin
            if (issue) g_q <= g_q + CW'(1);
            if (res_vld_q) acc_q <= acc_d;
            if (res_vld_q && res_last_q) cnt_q <= n_q;
         end
      end
   end

endmodule
